// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 10 bits clocked by the device, ack check.
// Optional PS2_TX_GLITCH_FILTER_EN: 8-cycle persistence filter on the synchronized ps2_clk.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 1500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t          state_reg;
    logic [1:0]      meta_reg;
    logic [1:0]      sync_reg;
    logic            clk_prev_reg;
    logic            fall_reg;
    logic            clk_cur;
    logic            data_cur;
    logic [9:0]      frame_reg;
    logic [3:0]      bit_idx_reg;
    logic [IW-1:0]   inhibit_cnt_reg;
    logic [TW-1:0]   timeout_cnt_reg;
    logic            tx_ready_reg;
    logic            busy_reg;
    logic            done_reg;
    logic            error_reg;
    logic            clk_dl_reg;
    logic            data_dl_reg;

    // Bit 0 carries ps2_clk, bit 1 carries ps2_data; idle bus level is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_reg <= 2'b11;
            sync_reg <= 2'b11;
        end else begin
            meta_reg <= {ps2_data_in, ps2_clk_in};
            sync_reg <= meta_reg;
        end
    end

    assign data_cur = sync_reg[1];

`ifdef PS2_TX_GLITCH_FILTER_EN
    logic       clk_filt_reg;
    logic [2:0] filt_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_filt_reg <= 1'b1;
            filt_cnt_reg <= 3'd0;
        end else if (sync_reg[0] != clk_filt_reg) begin
            if (filt_cnt_reg == 3'd7) begin
                clk_filt_reg <= sync_reg[0];
                filt_cnt_reg <= 3'd0;
            end else begin
                filt_cnt_reg <= filt_cnt_reg + 3'd1;
            end
        end else begin
            filt_cnt_reg <= 3'd0;
        end
    end

    assign clk_cur = clk_filt_reg;
`else
    assign clk_cur = sync_reg[0];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_prev_reg <= 1'b1;
            fall_reg     <= 1'b0;
        end else begin
            clk_prev_reg <= clk_cur;
            fall_reg     <= clk_prev_reg & ~clk_cur;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            frame_reg       <= '0;
            bit_idx_reg     <= '0;
            inhibit_cnt_reg <= '0;
            timeout_cnt_reg <= '0;
            tx_ready_reg    <= 1'b1;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            error_reg       <= 1'b0;
            clk_dl_reg      <= 1'b0;
            data_dl_reg     <= 1'b0;
        end else begin
            done_reg  <= 1'b0;
            error_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (tx_valid) begin
                        // Frame order on the wire: data LSB first, odd parity, stop (1 = released).
                        frame_reg       <= {1'b1, ~^tx_data, tx_data};
                        inhibit_cnt_reg <= '0;
                        clk_dl_reg      <= 1'b1;
                        tx_ready_reg    <= 1'b0;
                        busy_reg        <= 1'b1;
                        state_reg       <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (inhibit_cnt_reg == IW'(INHIBIT_CYCLES - 1)) begin
                        data_dl_reg <= 1'b1;
                        state_reg   <= REQ;
                    end else begin
                        inhibit_cnt_reg <= inhibit_cnt_reg + 1'b1;
                    end
                end
                REQ: begin
                    clk_dl_reg      <= 1'b0;
                    timeout_cnt_reg <= '0;
                    bit_idx_reg     <= '0;
                    state_reg       <= SEND;
                end
                SEND, ACK, WAIT_IDLE: begin
                    if (timeout_cnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
                        error_reg    <= 1'b1;
                        clk_dl_reg   <= 1'b0;
                        data_dl_reg  <= 1'b0;
                        tx_ready_reg <= 1'b1;
                        busy_reg     <= 1'b0;
                        state_reg    <= IDLE;
                    end else begin
                        timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
                        if (state_reg == SEND) begin
                            if (fall_reg) begin
                                data_dl_reg <= ~frame_reg[bit_idx_reg];
                                if (bit_idx_reg == 4'd9) begin
                                    state_reg <= ACK;
                                end else begin
                                    bit_idx_reg <= bit_idx_reg + 4'd1;
                                end
                            end
                        end else if (state_reg == ACK) begin
                            if (fall_reg) begin
                                if (!data_cur) begin
                                    state_reg <= WAIT_IDLE;
                                end else begin
                                    error_reg    <= 1'b1;
                                    tx_ready_reg <= 1'b1;
                                    busy_reg     <= 1'b0;
                                    state_reg    <= IDLE;
                                end
                            end
                        end else begin
                            if (clk_cur && data_cur) begin
                                done_reg     <= 1'b1;
                                tx_ready_reg <= 1'b1;
                                busy_reg     <= 1'b0;
                                state_reg    <= IDLE;
                            end
                        end
                    end
                end
                default: begin
                    clk_dl_reg   <= 1'b0;
                    data_dl_reg  <= 1'b0;
                    tx_ready_reg <= 1'b1;
                    busy_reg     <= 1'b0;
                    state_reg    <= IDLE;
                end
            endcase
        end
    end

    assign tx_ready           = tx_ready_reg;
    assign busy               = busy_reg;
    assign done               = done_reg;
    assign error              = error_reg;
    assign ps2_clk_drive_low  = clk_dl_reg;
    assign ps2_data_drive_low = data_dl_reg;

endmodule
